hist_ctrl: RTL

HIST_CTRL -- requirements
Module: hist_ctrl

---
 rtl/hist_pkg.sv | 18 +
 rtl/hist_ctrl_if.sv | 44 ++++
 rtl/sat_inc.sv | 13 +
 rtl/hist_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram controller: FSM state encoding,
// default geometry and statistics counter widths.
package hist_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 9;
  localparam int WORDS_DEF  = 512;
  localparam int TOTAL_W    = 32;
  localparam int LOST_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    CLR  = 2'd3
  } state_e;

endpackage

// File: rtl/hist_ctrl_if.sv
// Bundle of event input, clear control, host read, statistics and the two
// histogram RAM ports. "slave" is the controller's view, "master" the surroundings.
interface hist_ctrl_if #(
  parameter int DWIDTH = hist_pkg::DWIDTH_DEF,
  parameter int AWIDTH = hist_pkg::AWIDTH_DEF
);

  logic                       acq_en;
  logic                       ev_stb;
  logic [AWIDTH-1:0]          ev_ch;
  logic                       clr_start;
  logic                       clr_busy;
  logic                       clr_done;
  // Host reads have no back-pressure: each cycle rd_en is high is a request,
  // answered exactly one cycle later by rd_valid with rd_data; there is no ready.
  logic                       rd_en;
  logic [AWIDTH-1:0]          rd_addr;
  logic                       rd_valid;
  logic [DWIDTH-1:0]          rd_data;
  logic [hist_pkg::TOTAL_W-1:0] ev_total;
  logic [hist_pkg::LOST_W-1:0]  ev_lost;
  logic                       bin_ovf;
  logic [AWIDTH-1:0]          ram_addr1;
  logic [DWIDTH-1:0]          ram_d1;
  logic                       ram_load1;
  logic [DWIDTH-1:0]          ram_q1;
  logic [AWIDTH-1:0]          ram_addr2;
  logic [DWIDTH-1:0]          ram_d2;
  logic                       ram_load2;
  logic [DWIDTH-1:0]          ram_q2;

  modport slave (
    input  acq_en, ev_stb, ev_ch, clr_start, rd_en, rd_addr, ram_q1, ram_q2,
    output clr_busy, clr_done, rd_valid, rd_data, ev_total, ev_lost, bin_ovf,
    output ram_addr1, ram_d1, ram_load1, ram_addr2, ram_d2, ram_load2
  );

  modport master (
    output acq_en, ev_stb, ev_ch, clr_start, rd_en, rd_addr, ram_q1, ram_q2,
    input  clr_busy, clr_done, rd_valid, rd_data, ev_total, ev_lost, bin_ovf,
    input  ram_addr1, ram_d1, ram_load1, ram_addr2, ram_d2, ram_load2
  );

endinterface

// File: rtl/sat_inc.sv
// Saturating +1: holds at all-ones and flags that the input was already full.
module sat_inc #(
  parameter int DWIDTH = hist_pkg::DWIDTH_DEF
) (
  input  logic [DWIDTH-1:0] a_i,
  output logic [DWIDTH-1:0] y_o,
  output logic              ovf_o
);

  assign ovf_o = &a_i;
  assign y_o   = ovf_o ? a_i : a_i + DWIDTH'(1);

endmodule

// File: rtl/hist_ctrl.sv
// Histogram acquisition controller: read-modify-write of one bin per accepted
// event through RAM port 1, sequential bin clear, host reads through port 2.
module hist_ctrl
  import hist_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int WORDS  = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  hist_ctrl_if.slave  bus,
  output state_e      state_o
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   ch_q, ch_d;
  logic [AWIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                clr_pend_q, clr_pend_d;
  logic [TOTAL_W-1:0]  ev_total_q, ev_total_d;
  logic [LOST_W-1:0]   ev_lost_q, ev_lost_d;
  logic                bin_ovf_q, bin_ovf_d;
  logic                clr_done_q, clr_done_d;
  logic                rd_valid_q;

  logic                ev_live;
  logic                accept, drop, take_clr;
  logic [DWIDTH-1:0]   inc_val;
  logic                inc_ovf;
  logic [AWIDTH-1:0]   addr1;
  logic [DWIDTH-1:0]   d1;
  logic                load1;

  assign ev_live = bus.ev_stb & bus.acq_en;

  sat_inc #(.DWIDTH(DWIDTH)) u_sat_inc (
    .a_i   (bus.ram_q1),
    .y_o   (inc_val),
    .ovf_o (inc_ovf)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = clr_pend_q;
    ev_total_d = ev_total_q;
    ev_lost_d  = ev_lost_q;
    bin_ovf_d  = bin_ovf_q;
    clr_done_d = 1'b0;
    addr1      = '0;
    d1         = '0;
    load1      = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    take_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.clr_start) take_clr = 1'b1;
        else if (ev_live)  accept   = 1'b1;
      end
      RD: begin
        addr1   = ch_q;
        state_d = WR;
        if (bus.clr_start) clr_pend_d = 1'b1;
        if (ev_live)       drop       = 1'b1;
      end
      WR: begin
        // The write lands at this edge, so an RD of the same bin next cycle sees it.
        addr1 = ch_q;
        d1    = inc_val;
        load1 = 1'b1;
        if (inc_ovf) bin_ovf_d = 1'b1;
        if (clr_pend_q)   take_clr = 1'b1;
        else if (ev_live) accept   = 1'b1;
        else              state_d  = IDLE;
      end
      CLR: begin
        addr1 = clr_addr_q;
        load1 = 1'b1;
        if (ev_live) drop = 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + AWIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      ch_d       = bus.ev_ch;
      ev_total_d = ev_total_q + TOTAL_W'(1);
      state_d    = RD;
    end
    if (drop && (ev_lost_q != '1)) ev_lost_d = ev_lost_q + LOST_W'(1);
    // A taken clear overrides everything counted in the same cycle.
    if (take_clr) begin
      ev_total_d = '0;
      ev_lost_d  = '0;
      bin_ovf_d  = 1'b0;
      clr_pend_d = 1'b0;
      clr_addr_d = '0;
      state_d    = CLR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      clr_addr_q <= '0;
      clr_pend_q <= 1'b0;
      ev_total_q <= '0;
      ev_lost_q  <= '0;
      bin_ovf_q  <= 1'b0;
      clr_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
      ev_total_q <= ev_total_d;
      ev_lost_q  <= ev_lost_d;
      bin_ovf_q  <= bin_ovf_d;
      clr_done_q <= clr_done_d;
      rd_valid_q <= bus.rd_en;
    end
  end

  assign bus.ram_addr1 = addr1;
  assign bus.ram_d1    = d1;
  assign bus.ram_load1 = load1;
  assign bus.ram_addr2 = bus.rd_addr;
  assign bus.ram_d2    = '0;
  assign bus.ram_load2 = 1'b0;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = bus.ram_q2;
  assign bus.clr_busy  = (state_q == CLR);
  assign bus.clr_done  = clr_done_q;
  assign bus.ev_total  = ev_total_q;
  assign bus.ev_lost   = ev_lost_q;
  assign bus.bin_ovf   = bin_ovf_q;
  assign state_o       = state_q;

endmodule
